// File: rtl/mxu_input_skew.sv
// Activation feeder for mxu_core: buffers row vectors, issues one per cycle into a diagonal skew (lane i +i cycles).
// Issue is at least one edge after push (no fall-through); s_ready is plain ~full, with no same-cycle pop bypass.
module mxu_input_skew #(
    parameter int M              = 3,
    parameter int max_data_width = 8,
    parameter int DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [M*max_data_width-1:0]       s_data,
    input  logic                              core_ready,
    output logic [M*max_data_width-1:0]       input_data,
    output logic                              enable,
    output logic [$clog2(DEPTH):0]            fifo_count,
    output logic                              busy
);
    localparam int W  = max_data_width;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [M*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [M-1:0]   tok_q, tok_d;
    logic           push;
    logic           pop;
    logic [M*W-1:0] issue_dat;

    assign s_ready    = (count_q != CW'(DEPTH));
    assign push       = s_valid && s_ready && !flush;
    assign pop        = (count_q != '0) && core_ready && !flush;
    // Idle cycles feed zeros so bubbles travel down the diagonal like real data.
    assign issue_dat  = pop ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign enable     = |tok_q;
    assign busy       = (count_q != '0) || enable;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    // Token bit k marks a vector whose lane k is on the output this cycle.
    always_comb begin
        tok_d    = tok_q << 1;
        tok_d[0] = pop;
        if (flush) tok_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tok_q <= '0;
        else       tok_q <= tok_d;
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        logic [W-1:0] stg_q [i+1];
        logic [W-1:0] stg_d [i+1];

        always_comb begin
            for (int s = 0; s <= i; s++) stg_d[s] = '0;
            if (!flush) begin
                stg_d[0] = issue_dat[i*W +: W];
                for (int s = 1; s <= i; s++) stg_d[s] = stg_q[s-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) stg_q[s] <= '0;
            end else begin
                for (int s = 0; s <= i; s++) stg_q[s] <= stg_d[s];
            end
        end

        assign input_data[i*W +: W] = stg_q[i];
    end

endmodule

// File: tb/tb_mxu_input_skew.sv
// Bench for mxu_input_skew (M=3, W=8, DEPTH=4): per-edge expectations queued by stimulus, checked by a monitor.
module tb_mxu_input_skew;
    logic        clk = 0;
    logic        reset = 0;
    logic        flush = 0;
    logic        s_valid = 0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        core_ready = 0;
    logic [23:0] input_data;
    logic        enable;
    logic [2:0]  fifo_count;
    logic        busy;

    mxu_input_skew #(.M(3), .max_data_width(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_ready(core_ready), .input_data(input_data), .enable(enable),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          c;
        logic [23:0] d;
        logic        en;
        logic [2:0]  cnt;
        logic        rdy;
        logic        bsy;
    } exp_t;

    exp_t        q[$];
    logic [23:0] idat [int];   // hand-planned issue edge -> vector
    bit          kill [int];   // edges at which flush/reset wipes the skew
    int          total = 0;
    int          bad = 0;

    function automatic bit live(int ic, int e);
        for (int c = ic + 1; c <= e; c++) if (kill.exists(c)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] wave(int e);
        logic [23:0] r, v;
        r = '0;
        for (int i = 0; i < 3; i++)
            if (idat.exists(e - i) && live(e - i, e)) begin
                v = idat[e - i];
                r[i*8 +: 8] = v[i*8 +: 8];
            end
        return r;
    endfunction

    function automatic logic en_at(int e);
        for (int i = 0; i < 3; i++)
            if (idat.exists(e - i) && live(e - i, e)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic expect_at(int c, logic [2:0] cnt);
        exp_t e;
        e.c   = c;
        e.d   = wave(c);
        e.en  = en_at(c);
        e.cnt = cnt;
        e.rdy = (cnt != 3'd4);
        e.bsy = (cnt != 3'd0) || e.en;
        q.push_back(e);
    endtask

    task automatic chk(string nm, logic [23:0] got, logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic logic [23:0] fv(int i);
        return {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
    endfunction

    function automatic logic [23:0] wv(int i);
        return {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i)};
    endfunction

    // Monitor: after every edge, pop and compare the entries due for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.c < cyc) begin
                    bad++;
                    $display("FAIL missed@%0d: entry not checked, now edge %0d", e.c, cyc);
                end else if (input_data !== e.d || enable !== e.en || fifo_count !== e.cnt ||
                             s_ready !== e.rdy || busy !== e.bsy) begin
                    bad++;
                    $display("FAIL wave@%0d: got d=%h en=%b cnt=%0d rdy=%b busy=%b want d=%h en=%b cnt=%0d rdy=%b busy=%b",
                             cyc, input_data, enable, fifo_count, s_ready, busy,
                             e.d, e.en, e.cnt, e.rdy, e.bsy);
                end
            end
        end
    end

    initial begin
        int b;
        int sent;
        bit acc;
        logic [2:0] wrap_cnt [24];
        logic [2:0] fill_cnt [14];

        wrap_cnt = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4,
                     3'd3, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        fill_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

        #1 reset = 1;
        #1;
        chk("rst_data",  input_data, 24'h0);
        chk("rst_en",    {23'h0, enable}, 24'h0);
        chk("rst_ready", {23'h0, s_ready}, 24'h1);
        chk("rst_count", {21'h0, fifo_count}, 24'h0);
        chk("rst_busy",  {23'h0, busy}, 24'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // Single vector
        b = cyc;
        idat[b+2] = 24'hFECAFE;
        expect_at(b+1, 3'd1);
        for (int k = 2; k <= 5; k++) expect_at(b+k, 3'd0);
        core_ready = 1; s_valid = 1; s_data = 24'hFECAFE;
        @(negedge clk);
        s_valid = 0;
        repeat (4) @(negedge clk);

        // Fill with core_ready low, then drain
        b = cyc;
        for (int i = 0; i < 5; i++) idat[b+7+i] = fv(i);
        for (int k = 0; k < 14; k++) expect_at(b+1+k, fill_cnt[k]);
        core_ready = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = fv(i);
            @(negedge clk);
        end
        s_data = fv(4);
        repeat (2) @(negedge clk);
        core_ready = 1;
        repeat (2) @(negedge clk);
        s_valid = 0;
        repeat (6) @(negedge clk);

        // Back-to-back stream, diagonal overlap
        b = cyc;
        idat[b+2] = 24'hF111FE; idat[b+3] = 24'hF222FE; idat[b+4] = 24'hF333FE;
        expect_at(b+1, 3'd1); expect_at(b+2, 3'd1); expect_at(b+3, 3'd1);
        for (int k = 4; k <= 7; k++) expect_at(b+k, 3'd0);
        core_ready = 1;
        s_valid = 1; s_data = 24'hF111FE; @(negedge clk);
        s_data = 24'hF222FE; @(negedge clk);
        s_data = 24'hF333FE; @(negedge clk);
        s_valid = 0;
        @(negedge clk);
        chk("stream_overlap", input_data, 24'hF122FE);
        repeat (3) @(negedge clk);

        // Pointer wrap with core_ready toggling 1,0
        b = cyc;
        for (int i = 0; i < 10; i++) idat[b+3+2*i] = wv(i);
        for (int k = 0; k < 24; k++) expect_at(b+1+k, wrap_cnt[k]);
        sent = 0; acc = 0;
        for (int k = 0; k < 24; k++) begin
            if (acc) sent++;
            s_valid    = (sent < 10);
            s_data     = (sent < 10) ? wv(sent) : 24'h0;
            core_ready = (k % 2 == 0);
            acc        = s_valid && s_ready;
            @(negedge clk);
        end
        s_valid = 0;

        // Flush mid-flight, with a vector offered during flush
        b = cyc;
        idat[b+2] = 24'h112233; idat[b+3] = 24'h445566; kill[b+4] = 1;
        expect_at(b+1, 3'd1); expect_at(b+2, 3'd1); expect_at(b+3, 3'd1);
        for (int k = 4; k <= 6; k++) expect_at(b+k, 3'd0);
        core_ready = 1;
        s_valid = 1; s_data = 24'h112233; @(negedge clk);
        s_data = 24'h445566; @(negedge clk);
        s_data = 24'h778899; @(negedge clk);
        flush = 1; s_data = 24'hDDEEFF; @(negedge clk);
        flush = 0; s_valid = 0;
        repeat (2) @(negedge clk);

        // Async reset mid-stream, then single-vector timing again
        b = cyc;
        idat[b+2] = 24'h0A0B0C; idat[b+3] = 24'h0D0E0F; kill[b+4] = 1;
        idat[b+7] = 24'h123456;
        expect_at(b+1, 3'd1); expect_at(b+2, 3'd1); expect_at(b+3, 3'd0);
        expect_at(b+5, 3'd0); expect_at(b+6, 3'd1);
        for (int k = 7; k <= 10; k++) expect_at(b+k, 3'd0);
        core_ready = 1;
        s_valid = 1; s_data = 24'h0A0B0C; @(negedge clk);
        s_data = 24'h0D0E0F; @(negedge clk);
        s_valid = 0; @(negedge clk);
        #1 reset = 1;
        #1;
        chk("arst_data",  input_data, 24'h0);
        chk("arst_en",    {23'h0, enable}, 24'h0);
        chk("arst_ready", {23'h0, s_ready}, 24'h1);
        chk("arst_count", {21'h0, fifo_count}, 24'h0);
        chk("arst_busy",  {23'h0, busy}, 24'h0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        s_valid = 1; s_data = 24'h123456; @(negedge clk);
        s_valid = 0;
        repeat (4) @(negedge clk);

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
